decode_ctrl: RTL and testbench
==============================

DECODE_CTRL -- requirements
Module: decode_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 32, width of the decoded-instruction counter.
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  upstream fetch word valid.
REQ-005 SHALL have port in_ready  output  1  block can accept a word this cycle.
REQ-006 SHALL have port in_inst  input  32  fetched instruction.
REQ-007 SHALL have port in_pc  input  32  PC of in_inst.
REQ-008 SHALL have port flush  input  1  discard all buffered and incoming words.
REQ-009 SHALL have port out_valid  output  1  head entry valid toward execute stage.
REQ-010 SHALL have port out_ready  input  1  execute stage accepts head entry.
REQ-011 SHALL have port out_inst  output  32  head instruction, wired to imm_gen inst.
REQ-012 SHALL have port out_pc  output  32  head PC.
REQ-013 SHALL have port imm_sel  output  3  immediate format for head, wired to imm_gen imm_sel.
REQ-014 SHALL have port uses_imm  output  1  head instruction consumes an immediate.
REQ-015 SHALL have port illegal  output  1  head opcode not in RV32I base set.
REQ-016 SHALL have port dec_cnt  output  CNT_W  count of output handshakes.

Function
REQ-017 SHALL hold a 2-entry FIFO (skid buffer) of {inst, pc}; FSM states EMPTY, ONE, TWO.
REQ-018 SHALL assert in_ready from registered state only: 1 in EMPTY/ONE, 0 in TWO (no combinational path from out_ready).
REQ-019 SHALL accept a word when in_valid && in_ready; SHALL pop head when out_valid && out_ready.
REQ-020 SHALL transition: EMPTY+accept->ONE; ONE+accept+no pop->TWO; ONE+pop+no accept->EMPTY; ONE+accept+pop->ONE; TWO+pop->ONE; otherwise hold.
REQ-021 SHALL drive out_valid = (state != EMPTY); out_inst/out_pc = head entry; data in the second entry SHALL advance to head on pop, preserving order.
REQ-022 SHALL present a word at the output the cycle after acceptance (latency 1); no bypass of the same-cycle word.
REQ-023 SHALL decode imm_sel/uses_imm/illegal combinationally from head out_inst[6:0]: 0010011, 0000011, 1100111, 1110011, 0001111 -> IMM_SEL_I; 0100011 -> IMM_SEL_S; 1100011 -> IMM_SEL_SB; 1101111 -> IMM_SEL_UJ; 0110111, 0010111 -> IMM_SEL_U; uses_imm=1 for all these.
REQ-024 SHALL drive, for opcode 0110011, imm_sel=3'b111, uses_imm=0, illegal=0.
REQ-025 SHALL drive, for any other opcode (incl. inst[1:0]!=2'b11), imm_sel=3'b111, uses_imm=0, illegal=1.
REQ-026 SHALL force imm_sel=3'b111, uses_imm=0, illegal=0 while out_valid=0.
REQ-027 SHALL, on flush, go to EMPTY at the next edge, dropping buffered entries and any word accepted that cycle; a pop coinciding with flush SHALL still count.
REQ-028 SHALL increment dec_cnt by 1 per output handshake, wrapping modulo 2^CNT_W.
REQ-029 SHALL not pass an illegal word any differently: it is buffered and popped like any other.

Reset
REQ-030 SHALL, while rst=1 at a clock edge, set state=EMPTY, dec_cnt=0, FIFO storage to 0; rst SHALL take priority over flush and handshakes.
REQ-031 SHALL, in the cycle after reset, show in_ready=1, out_valid=0, out_inst=0, out_pc=0, imm_sel=3'b111, uses_imm=0, illegal=0.

Verification
REQ-032 SHALL cover: reset, then in_inst=0x00500093 (addi), pc=0x0, out_ready=1 -> next cycle out_valid=1, imm_sel=IMM_SEL_I, uses_imm=1, dec_cnt=1 after pop.
REQ-033 SHALL cover: out_ready=0, push sw 0x00112023 then beq 0x00000063 -> state TWO, in_ready=0; raise out_ready -> S then SB in order, in_ready=1 after first pop.
REQ-034 SHALL cover: push 0x00000000 -> illegal=1, uses_imm=0, imm_sel=3'b111; push add 0x002081B3 -> illegal=0, uses_imm=0.
REQ-035 SHALL cover: state TWO with flush=1 and in_valid=1 same cycle -> next cycle out_valid=0, in_ready=1, dropped words never appear.
REQ-036 SHALL cover: CNT_W=4, 16 pops -> dec_cnt wraps to 0; rst mid-stream in TWO -> EMPTY, dec_cnt=0 next cycle.
REQ-037 SHALL cover: jal 0x0000006F and lui 0x000010B7 back-to-back with out_ready=1 -> IMM_SEL_UJ then IMM_SEL_U on consecutive cycles, sustained 1 word/cycle.

Source files
------------

// File: rtl/decode_ctrl.sv
// decode_ctrl: two-entry skid buffer between fetch and execute, plus a
// head-of-queue opcode decoder that steers the downstream immediate generator.
//
// Ports:
//   clk        rising-edge clock for all state
//   rst        synchronous, active-high reset
//   in_valid   fetch word valid
//   in_ready   buffer can take a word this cycle (registered, never from out_ready)
//   in_inst    fetched instruction
//   in_pc      PC of in_inst
//   flush      drop buffered words and any word accepted this cycle
//   out_valid  head entry valid toward execute
//   out_ready  execute accepts the head entry
//   out_inst   head instruction (feeds imm_gen inst)
//   out_pc     head PC
//   imm_sel    immediate format of the head (feeds imm_gen imm_sel)
//   uses_imm   head consumes an immediate
//   illegal    head opcode is outside RV32I base set
//   dec_cnt    number of output handshakes, wraps modulo 2^CNT_W
module decode_ctrl #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [31:0]      in_pc,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_inst,
    output logic [31:0]      out_pc,
    output logic [2:0]       imm_sel,
    output logic             uses_imm,
    output logic             illegal,
    output logic [CNT_W-1:0] dec_cnt
);

    localparam logic [2:0] ImmSelI    = 3'b000;
    localparam logic [2:0] ImmSelS    = 3'b001;
    localparam logic [2:0] ImmSelSb   = 3'b010;
    localparam logic [2:0] ImmSelUj   = 3'b011;
    localparam logic [2:0] ImmSelU    = 3'b100;
    localparam logic [2:0] ImmSelNone = 3'b111;

    typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

    state_e             state_q, state_d;
    logic [31:0]        head_inst_q, head_inst_d;
    logic [31:0]        head_pc_q, head_pc_d;
    logic [31:0]        tail_inst_q, tail_inst_d;
    logic [31:0]        tail_pc_q, tail_pc_d;
    logic [CNT_W-1:0]   cnt_q;

    logic accept;
    logic pop;

    assign in_ready  = (state_q != StTwo);
    assign out_valid = (state_q != StEmpty);
    assign out_inst  = head_inst_q;
    assign out_pc    = head_pc_q;
    assign dec_cnt   = cnt_q;

    assign accept = in_valid && in_ready;
    assign pop    = out_valid && out_ready;

    always_comb begin
        state_d     = state_q;
        head_inst_d = head_inst_q;
        head_pc_d   = head_pc_q;
        tail_inst_d = tail_inst_q;
        tail_pc_d   = tail_pc_q;
        unique case (state_q)
            StEmpty: begin
                if (accept) begin
                    state_d     = StOne;
                    head_inst_d = in_inst;
                    head_pc_d   = in_pc;
                end
            end
            StOne: begin
                if (accept && pop) begin
                    head_inst_d = in_inst;
                    head_pc_d   = in_pc;
                end else if (accept) begin
                    state_d     = StTwo;
                    tail_inst_d = in_inst;
                    tail_pc_d   = in_pc;
                end else if (pop) begin
                    state_d = StEmpty;
                end
            end
            StTwo: begin
                // in_ready is low here, so only a pop can occur.
                if (pop) begin
                    state_d     = StOne;
                    head_inst_d = tail_inst_q;
                    head_pc_d   = tail_pc_q;
                end
            end
            default: state_d = StEmpty;
        endcase
        // Flush empties the queue; stale storage is hidden by out_valid=0.
        if (flush) begin
            state_d = StEmpty;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StEmpty;
            head_inst_q <= '0;
            head_pc_q   <= '0;
            tail_inst_q <= '0;
            tail_pc_q   <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            head_inst_q <= head_inst_d;
            head_pc_q   <= head_pc_d;
            tail_inst_q <= tail_inst_d;
            tail_pc_q   <= tail_pc_d;
            // A pop that coincides with flush still reached execute.
            if (pop) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        imm_sel  = ImmSelNone;
        uses_imm = 1'b0;
        illegal  = 1'b0;
        if (out_valid) begin
            unique case (out_inst[6:0])
                7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011, 7'b0001111: begin
                    imm_sel  = ImmSelI;
                    uses_imm = 1'b1;
                end
                7'b0100011: begin
                    imm_sel  = ImmSelS;
                    uses_imm = 1'b1;
                end
                7'b1100011: begin
                    imm_sel  = ImmSelSb;
                    uses_imm = 1'b1;
                end
                7'b1101111: begin
                    imm_sel  = ImmSelUj;
                    uses_imm = 1'b1;
                end
                7'b0110111, 7'b0010111: begin
                    imm_sel  = ImmSelU;
                    uses_imm = 1'b1;
                end
                7'b0110011: begin
                    // R-type: legal, no immediate.
                end
                default: begin
                    illegal = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_decode_ctrl.sv
// Directed bench for decode_ctrl (CNT_W=4 so the counter wrap is reachable).
module tb_decode_ctrl;

    localparam logic [2:0] SEL_I    = 3'b000;
    localparam logic [2:0] SEL_S    = 3'b001;
    localparam logic [2:0] SEL_SB   = 3'b010;
    localparam logic [2:0] SEL_UJ   = 3'b011;
    localparam logic [2:0] SEL_U    = 3'b100;
    localparam logic [2:0] SEL_NONE = 3'b111;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [31:0] in_pc;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic [2:0]  imm_sel;
    logic        uses_imm;
    logic        illegal;
    logic [3:0]  dec_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    decode_ctrl #(.CNT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_inst   (in_inst),
        .in_pc     (in_pc),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_inst  (out_inst),
        .out_pc    (out_pc),
        .imm_sel   (imm_sel),
        .uses_imm  (uses_imm),
        .illegal   (illegal),
        .dec_cnt   (dec_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_inst = '0; in_pc = '0; flush = 1'b0; out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_inst", out_inst, 0);
        check("rst_out_pc", out_pc, 0);
        check("rst_imm_sel", imm_sel, SEL_NONE);
        check("rst_uses_imm", uses_imm, 0);
        check("rst_illegal", illegal, 0);
        check("rst_dec_cnt", dec_cnt, 0);

        // addi, latency 1 then pop
        in_valid = 1'b1; in_inst = 32'h00500093; in_pc = 32'h0; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check("addi_valid", out_valid, 1);
        check("addi_inst", out_inst, 32'h00500093);
        check("addi_sel", imm_sel, SEL_I);
        check("addi_uses", uses_imm, 1);
        check("addi_illegal", illegal, 0);
        check("addi_cnt_pre", dec_cnt, 0);
        tick();
        check("addi_cnt", dec_cnt, 1);
        check("addi_empty", out_valid, 0);

        // sw then beq while stalled -> full
        out_ready = 1'b0;
        in_valid = 1'b1; in_inst = 32'h00112023; in_pc = 32'h4;
        tick();
        in_inst = 32'h00000063; in_pc = 32'h8;
        tick();
        in_valid = 1'b0;
        check("full_in_ready", in_ready, 0);
        check("full_out_valid", out_valid, 1);
        check("sw_inst", out_inst, 32'h00112023);
        check("sw_pc", out_pc, 32'h4);
        check("sw_sel", imm_sel, SEL_S);
        out_ready = 1'b1;
        tick();
        check("pop1_in_ready", in_ready, 1);
        check("beq_inst", out_inst, 32'h00000063);
        check("beq_pc", out_pc, 32'h8);
        check("beq_sel", imm_sel, SEL_SB);
        check("beq_cnt", dec_cnt, 2);
        tick();
        check("beq_done_valid", out_valid, 0);
        check("beq_done_cnt", dec_cnt, 3);

        // illegal zero word, then R-type add
        out_ready = 1'b0;
        in_valid = 1'b1; in_inst = 32'h00000000; in_pc = 32'hC;
        tick();
        check("zero_illegal", illegal, 1);
        check("zero_uses", uses_imm, 0);
        check("zero_sel", imm_sel, SEL_NONE);
        check("zero_valid", out_valid, 1);
        in_inst = 32'h002081B3; in_pc = 32'h10;
        tick();
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        check("add_inst", out_inst, 32'h002081B3);
        check("add_illegal", illegal, 0);
        check("add_uses", uses_imm, 0);
        check("add_sel", imm_sel, SEL_NONE);
        check("add_cnt", dec_cnt, 4);
        tick();
        check("add_cnt_done", dec_cnt, 5);

        // flush while full with an incoming word
        out_ready = 1'b0;
        in_valid = 1'b1; in_inst = 32'h00000013; in_pc = 32'h20;
        tick();
        in_inst = 32'h00100113; in_pc = 32'h24;
        tick();
        check("pre_flush_full", in_ready, 0);
        flush = 1'b1; in_inst = 32'h00200193; in_pc = 32'h28;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("flush_out_valid", out_valid, 0);
        check("flush_in_ready", in_ready, 1);
        check("flush_cnt", dec_cnt, 5);
        in_valid = 1'b1; in_inst = 32'h00300213; in_pc = 32'h30; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check("post_flush_inst", out_inst, 32'h00300213);
        check("post_flush_pc", out_pc, 32'h30);
        tick();
        check("post_flush_cnt", dec_cnt, 6);
        check("post_flush_empty", out_valid, 0);

        // flush coinciding with pop still counts; word accepted that cycle dropped
        out_ready = 1'b0;
        in_valid = 1'b1; in_inst = 32'h00400293; in_pc = 32'h34;
        tick();
        out_ready = 1'b1; flush = 1'b1; in_inst = 32'h00500313; in_pc = 32'h38;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("flush_pop_cnt", dec_cnt, 7);
        check("flush_pop_valid", out_valid, 0);

        // jal then lui back-to-back, 1 word/cycle
        in_valid = 1'b1; in_inst = 32'h0000006F; in_pc = 32'h40;
        tick();
        check("jal_inst", out_inst, 32'h0000006F);
        check("jal_sel", imm_sel, SEL_UJ);
        check("jal_in_ready", in_ready, 1);
        in_inst = 32'h000010B7; in_pc = 32'h44;
        tick();
        in_valid = 1'b0;
        check("lui_inst", out_inst, 32'h000010B7);
        check("lui_sel", imm_sel, SEL_U);
        check("lui_valid", out_valid, 1);
        check("lui_cnt", dec_cnt, 8);
        tick();
        check("lui_done_cnt", dec_cnt, 9);

        // stream 7 more pops: total 16 handshakes -> counter wraps to 0
        in_valid = 1'b1;
        for (int i = 0; i < 7; i++) begin
            in_inst = 32'h00000013; in_pc = 32'h100 + 32'(4 * i);
            tick();
        end
        in_valid = 1'b0;
        check("wrap_pre_cnt", dec_cnt, 15);
        tick();
        check("wrap_cnt", dec_cnt, 0);
        check("wrap_empty", out_valid, 0);

        // reset mid-stream while full
        in_valid = 1'b1; in_inst = 32'h00000013; in_pc = 32'h200;
        tick();
        in_valid = 1'b0;
        tick();
        check("pre_rst_cnt", dec_cnt, 1);
        out_ready = 1'b0; in_valid = 1'b1; in_inst = 32'h00112023; in_pc = 32'h204;
        tick();
        in_inst = 32'h00000063; in_pc = 32'h208;
        tick();
        check("pre_rst_full", in_ready, 0);
        rst = 1'b1; out_ready = 1'b1; flush = 1'b1;
        tick();
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_ready", in_ready, 1);
        check("mid_rst_cnt", dec_cnt, 0);
        check("mid_rst_inst", out_inst, 0);
        check("mid_rst_pc", out_pc, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
